// File: rtl/flag_board_if.sv
// Request, status and renderer-read signals of the flag storage stage.
// master drives coordinates/switches/read address; slave (flag_board) returns flags.
interface flag_board_if;
  logic [3:0] casilla_x;
  logic [3:0] casilla_y;
  logic [9:0] inputSwitchF;
  logic       cell_revealed;
  logic       clear_all;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic       rd_flag;
  logic [6:0] flag_count;
  logic [6:0] flags_left;
  logic       flag_ack;
  logic       flag_nack;
  logic       busy;

  modport master (
    output casilla_x, casilla_y, inputSwitchF, cell_revealed, clear_all, rd_x, rd_y,
    input  rd_flag, flag_count, flags_left, flag_ack, flag_nack, busy
  );

  modport slave (
    input  casilla_x, casilla_y, inputSwitchF, cell_revealed, clear_all, rd_x, rd_y,
    output rd_flag, flag_count, flags_left, flag_ack, flag_nack, busy
  );
endinterface

// File: rtl/flag_board.sv
// Per-cell flag bitmap with read-modify-write toggle FSM, flag counter and registered read port.
// Define FLAG_LIMIT_EN to reject setting flags once flag_count reaches MAX_FLAGS.
module flag_board #(
  parameter int unsigned GRID_W       = 8,
  parameter int unsigned GRID_H       = 8,
  parameter int unsigned MAX_FLAGS    = 10,
  parameter logic [9:0]  FLAG_PATTERN = 10'b1111111011
) (
  input logic         clk,
  input logic         reset,
  flag_board_if.slave bus
);

  localparam int unsigned NCELLS = GRID_W * GRID_H;
  localparam int unsigned IDXW   = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [IDXW-1:0] LAST_CELL = IDXW'(NCELLS - 1);
  localparam logic [4:0] GRID_W5 = 5'(GRID_W);
  localparam logic [4:0] GRID_H5 = 5'(GRID_H);
  localparam logic [6:0] MAX7    = 7'(MAX_FLAGS);

  typedef enum logic [1:0] {StClear, StIdle, StUpdate, StHold} state_e;

  state_e          state_q;
  logic [IDXW-1:0] sweep_q;
  logic [IDXW-1:0] cell_q;
  logic            cur_bit_q;
  logic [6:0]      count_q;
  logic            ack_q;
  logic            nack_q;
  logic            rd_flag_q;
  logic            mem [NCELLS];

  logic            req;
  logic            req_ok;
  logic            rd_ok;
  logic [8:0]      req_lin;
  logic [8:0]      rd_lin;
  logic [IDXW-1:0] req_idx;
  logic [IDXW-1:0] rd_idx;
  logic            set_blocked;
  logic            upd_we;

  always_comb begin
    req     = (bus.inputSwitchF == FLAG_PATTERN);
    req_ok  = ({1'b0, bus.casilla_x} < GRID_W5) && ({1'b0, bus.casilla_y} < GRID_H5);
    rd_ok   = ({1'b0, bus.rd_x} < GRID_W5) && ({1'b0, bus.rd_y} < GRID_H5);
    req_lin = 9'(bus.casilla_y) * 9'(GRID_W) + 9'(bus.casilla_x);
    rd_lin  = 9'(bus.rd_y) * 9'(GRID_W) + 9'(bus.rd_x);
    req_idx = req_lin[IDXW-1:0];
    rd_idx  = rd_lin[IDXW-1:0];
  end

  // The 7-bit counter must never wrap, so a full counter also blocks a set.
`ifdef FLAG_LIMIT_EN
  assign set_blocked = (count_q >= MAX7) || (count_q == 7'h7f);
`else
  assign set_blocked = (count_q == 7'h7f);
`endif

  assign upd_we = (state_q == StUpdate) && (cur_bit_q || !set_blocked);

  // Single write port: sweep in CLEAR, toggle in UPDATE; reset drops a pending toggle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StClear) begin
        mem[sweep_q] <= 1'b0;
      end else if (upd_we) begin
        mem[cell_q] <= ~cur_bit_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      sweep_q   <= '0;
      cell_q    <= '0;
      cur_bit_q <= 1'b0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      rd_flag_q <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      rd_flag_q <= (state_q != StClear) && rd_ok && mem[rd_idx];
      unique case (state_q)
        StClear: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == LAST_CELL) begin
            sweep_q <= '0;
            count_q <= '0;
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (bus.clear_all) begin
            sweep_q   <= '0;
            rd_flag_q <= 1'b0;
            state_q   <= StClear;
          end else if (req) begin
            cell_q    <= req_idx;
            cur_bit_q <= req_ok ? mem[req_idx] : 1'b0;
            if (!req_ok || bus.cell_revealed) begin
              nack_q  <= 1'b1;
              state_q <= StHold;
            end else begin
              state_q <= StUpdate;
            end
          end
        end
        StUpdate: begin
          if (cur_bit_q) begin
            count_q <= count_q - 1'b1;
            ack_q   <= 1'b1;
          end else if (set_blocked) begin
            nack_q  <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
            ack_q   <= 1'b1;
          end
          // The toggle always completes; a pending wipe starts right after it.
          if (bus.clear_all) begin
            sweep_q   <= '0;
            rd_flag_q <= 1'b0;
            state_q   <= StClear;
          end else begin
            state_q <= StHold;
          end
        end
        StHold: begin
          if (bus.clear_all) begin
            sweep_q   <= '0;
            rd_flag_q <= 1'b0;
            state_q   <= StClear;
          end else if (!req) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign bus.rd_flag    = rd_flag_q;
  assign bus.flag_count = count_q;
  assign bus.flags_left = (count_q >= MAX7) ? 7'd0 : (MAX7 - count_q);
  assign bus.flag_ack   = ack_q;
  assign bus.flag_nack  = nack_q;
  assign bus.busy       = (state_q != StIdle);

endmodule
